counter_sched: RTL and testbench

Round-robin scheduler that shares one loadable up-counter (clk/load/enab/rst/cnt_in/cnt_out) between NREQ requesters. Each requester presents a start and end value. The scheduler grants one requester at a time, loads the counter with that requester's start value, and enables counting until the counter output equals the end value. It then pulses that requester's done line. The block sits between the requesting control logic and the shared counter instance and is the only driver of the counter's control inputs.

---
 rtl/counter_sched.sv | 185 ++++++++++++++++++
 tb/tb_counter_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: round-robin arbiter in front of one shared loadable up-counter.
// Each requester supplies a start/end value pair. The winner's pair is latched,
// the counter is loaded with the start value, and counting runs until the
// counter output equals the end value. A one-cycle done pulse then goes back
// to that requester.
//
// Optional feature macro: COUNTER_SCHED_ABORT_EN
//   defined   - dropping req[id] during RUN abandons the job through CLR
//   undefined - req is ignored once granted; every job reaches DONE
//
// Handshake: req[i] is a level request. The scheduler samples it only in IDLE.
// gnt[i] stays high from LOAD through DONE. done[i] is the completion strobe and
// lasts exactly one cycle. No new grant decision is taken in DONE.
module counter_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_start,
    input  logic [NREQ*WIDTH-1:0] req_end,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_rst,
    output logic                  cnt_load,
    output logic                  cnt_enab,
    output logic [WIDTH-1:0]      cnt_in,
    input  logic [WIDTH-1:0]      cnt_out,
    output logic [2:0]            dbg_state
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_IDLE = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;

    logic [WIDTH-1:0] start_arr [NREQ];
    logic [WIDTH-1:0] end_arr   [NREQ];

    logic             found;
    logic [IDW-1:0]   win_id;

    // Unpack the flat start/end buses into per-requester fields.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            start_arr[i] = req_start[i*WIDTH +: WIDTH];
            end_arr[i]   = req_end[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: the first requester above last_id wins; if none is
    // above it, wrap to the lowest-numbered requester (which may be last_id).
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i > int'(last_id_q))) begin
                found  = 1'b1;
                win_id = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                win_id = IDW'(i);
            end
        end
    end

    // Next-state logic plus all counter-control and requester-side outputs.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        start_d   = start_q;
        end_d     = end_q;
        gnt       = '0;
        done      = '0;
        busy      = 1'b0;
        cnt_rst   = 1'b0;
        cnt_load  = 1'b0;
        cnt_enab  = 1'b0;
        cnt_in    = '0;

        case (state_q)
            S_CLR: begin
                cnt_rst = 1'b1;
                state_d = S_IDLE;
            end

            S_IDLE: begin
                // start/end are captured here only, so the running job does not
                // follow later changes on the request buses.
                if (found) begin
                    id_d    = win_id;
                    start_d = start_arr[win_id];
                    end_d   = end_arr[win_id];
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                gnt[id_q] = 1'b1;
                busy      = 1'b1;
                cnt_load  = 1'b1;
                cnt_in    = start_q;
                state_d   = S_RUN;
            end

            S_RUN: begin
                gnt[id_q] = 1'b1;
                busy      = 1'b1;
`ifdef COUNTER_SCHED_ABORT_EN
                // Withdrawn request: freeze the counter now and clear it via CLR.
                // The aborted requester still counts as served for fairness.
                if (!req[id_q]) begin
                    state_d   = S_CLR;
                    last_id_d = id_q;
                end else if (cnt_out == end_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_enab = 1'b1;
                end
`else
                // The counter is registered, so the first RUN cycle already sees
                // start_q; equality on that cycle means a zero-length job.
                if (cnt_out == end_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_enab = 1'b1;
                end
`endif
            end

            S_DONE: begin
                gnt[id_q]  = 1'b1;
                done[id_q] = 1'b1;
                last_id_d  = id_q;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_CLR;
            end
        endcase

        // Hold the shared counter cleared for the whole reset period as well.
        if (!rst_n) begin
            cnt_rst = 1'b1;
        end
    end

    // State and job registers; reset discards any job and favours requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLR;
            id_q      <= '0;
            last_id_q <= IDW'(NREQ - 1);
            start_q   <= '0;
            end_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            start_q   <= start_d;
            end_q     <= end_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed bench for counter_sched with a behavioural model
// of the shared counter. Inputs change on the falling edge and outputs are
// sampled on the falling edge. Abort behaviour is checked according to
// COUNTER_SCHED_ABORT_EN.
module tb_counter_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_start;
    logic [NREQ*WIDTH-1:0] req_end;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_rst;
    logic                  cnt_load;
    logic                  cnt_enab;
    logic [WIDTH-1:0]      cnt_in;
    logic [WIDTH-1:0]      cnt_out;
    logic [2:0]            dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] obs_q [$];
    logic [7:0]       exp_gd_q [$];

    counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_start (req_start),
        .req_end   (req_end),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt_rst   (cnt_rst),
        .cnt_load  (cnt_load),
        .cnt_enab  (cnt_enab),
        .cnt_in    (cnt_in),
        .cnt_out   (cnt_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared counter model: rst > load > enab, registered.
    always @(posedge clk) begin
        if (cnt_rst)       cnt_out <= '0;
        else if (cnt_load) cnt_out <= cnt_in;
        else if (cnt_enab) cnt_out <= cnt_out + 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic set_job(input int id, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e);
        req_start[id*WIDTH +: WIDTH] = s;
        req_end[id*WIDTH +: WIDTH]   = e;
    endtask

    // Reset for two cycles, release with req=r; returns in the first IDLE cycle.
    task automatic apply_reset(input logic [NREQ-1:0] r);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        @(negedge clk);
    endtask

    // Monitor: steps cycles until the first done pulse (or budget), collecting
    // what the DUT did. cycles stays -1 if no done was seen.
    task automatic run_to_done(input int budget, output int cycles, output int enab_n,
                               output logic [NREQ-1:0] gnt_seen, output logic [NREQ-1:0] done_seen,
                               output int load_at, output logic [WIDTH-1:0] load_in,
                               output int rst_seen);
        cycles = -1; enab_n = 0; gnt_seen = '0; done_seen = '0;
        load_at = -1; load_in = '0; rst_seen = 0;
        obs_q.delete();
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (cnt_rst) rst_seen++;
            if (cnt_load) begin
                load_at = c;
                load_in = cnt_in;
            end
            if (busy && !cnt_load) obs_q.push_back(cnt_out);
            if (cnt_enab) enab_n++;
            if (done != '0) begin
                cycles    = c;
                done_seen = done;
                gnt_seen  = gnt;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (cnt_rst !== 1'b1) begin
            failures++; $display("FAIL reset_cnt_rst got=%b exp=1", cnt_rst);
        end
        checks++;
        if ({gnt, done, busy, cnt_load, cnt_enab, cnt_in} !== 16'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {gnt, done, busy, cnt_load, cnt_enab, cnt_in});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cnt_rst !== 1'b1) begin
            failures++; $display("FAIL clr_cycle_cnt_rst got=%b exp=1", cnt_rst);
        end
        @(negedge clk);
        checks++;
        if (cnt_rst !== 1'b0 || gnt !== 4'b0000) begin
            failures++; $display("FAIL clr_one_cycle cnt_rst=%b gnt=%b exp 0/0000", cnt_rst, gnt);
        end
    endtask

    task automatic test_basic;
        int cyc, en_n, ld_at, rs_n;
        logic [NREQ-1:0] g_s, d_s;
        logic [WIDTH-1:0] ld_in, v;
        set_job(0, 5'd3, 5'd7);
        req = 4'b0001;
        run_to_done(30, cyc, en_n, g_s, d_s, ld_at, ld_in, rs_n);
        checks++;
        if (ld_at !== 1 || ld_in !== 5'd3) begin
            failures++; $display("FAIL basic_load at=%0d cnt_in=%0d exp at=1 cnt_in=3", ld_at, ld_in);
        end
        checks++;
        if (en_n !== 4) begin
            failures++; $display("FAIL basic_enab_cycles got=%0d exp=4", en_n);
        end
        checks++;
        if (cyc !== 7) begin
            failures++; $display("FAIL basic_latency got=%0d exp=7", cyc);
        end
        checks++;
        if (d_s !== 4'b0001 || g_s !== 4'b0001) begin
            failures++; $display("FAIL basic_done done=%b gnt=%b exp 0001/0001", d_s, g_s);
        end
        checks++;
        if (cnt_out !== 5'd7 || rs_n !== 0) begin
            failures++; $display("FAIL basic_final cnt_out=%0d rst_cycles=%0d exp 7/0", cnt_out, rs_n);
        end
        exp_q.delete();
        v = 5'd3;
        repeat (5) begin
            exp_q.push_back(v);
            v = v + 1'b1;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_run_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_seq[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]);
            end
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (done !== 4'b0000 || gnt !== 4'b0000) begin
            failures++; $display("FAIL basic_pulse_width done=%b gnt=%b exp 0000/0000", done, gnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [NREQ-1:0] g;
        logic [7:0] exp_v;
        for (int i = 0; i < NREQ; i++) set_job(i, 5'd0, 5'd1);
        exp_gd_q.delete();
        for (int j = 0; j < 5; j++) begin
            g = 4'(1 << (j % 4));
            exp_gd_q.push_back(8'h00);
            exp_gd_q.push_back({g, 4'b0000});
            exp_gd_q.push_back({g, 4'b0000});
            exp_gd_q.push_back({g, 4'b0000});
            exp_gd_q.push_back({g, g});
        end
        apply_reset(4'b1111);
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clk);
            exp_v = exp_gd_q.pop_front();
            checks++;
            if ({gnt, done} !== exp_v) begin
                failures++; $display("FAIL rr_cycle%0d gnt_done=%b exp=%b", c, {gnt, done}, exp_v);
            end
        end
    endtask

    task automatic test_wrap;
        int cyc, en_n, ld_at, rs_n, extra;
        logic [NREQ-1:0] g_s, d_s;
        logic [WIDTH-1:0] ld_in, v;
        apply_reset(4'b0000);
        set_job(1, 5'd30, 5'd2);
        req = 4'b0010;
        run_to_done(30, cyc, en_n, g_s, d_s, ld_at, ld_in, rs_n);
        checks++;
        if (ld_in !== 5'd30 || en_n !== 4 || cyc !== 7) begin
            failures++; $display("FAIL wrap_job cnt_in=%0d enab=%0d lat=%0d exp 30/4/7", ld_in, en_n, cyc);
        end
        checks++;
        if (d_s !== 4'b0010) begin
            failures++; $display("FAIL wrap_done got=%b exp=0010", d_s);
        end
        exp_q.delete();
        v = 5'd30;
        repeat (5) begin
            exp_q.push_back(v);
            v = v + 1'b1;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL wrap_run_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL wrap_seq[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]);
            end
        end
        req = '0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++; $display("FAIL wrap_single_done extra_pulses=%0d exp=0", extra);
        end
    endtask

    task automatic test_equal;
        set_job(2, 5'd9, 5'd9);
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || cnt_load !== 1'b1 || cnt_in !== 5'd9) begin
            failures++; $display("FAIL equal_load gnt=%b load=%b cnt_in=%0d exp 0100/1/9", gnt, cnt_load, cnt_in);
        end
        set_job(2, 5'd1, 5'd20);
        @(negedge clk);
        checks++;
        if (cnt_out !== 5'd9 || cnt_enab !== 1'b0) begin
            failures++; $display("FAIL equal_run cnt_out=%0d enab=%b exp 9/0", cnt_out, cnt_enab);
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0100) begin
            failures++; $display("FAIL equal_done got=%b exp=0100", done);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int cyc, en_n, ld_at, rs_n;
        logic [NREQ-1:0] g_s, d_s;
        logic [WIDTH-1:0] ld_in;
        set_job(1, 5'd0, 5'd20);
        req = 4'b0010;
        repeat (5) @(negedge clk);
        checks++;
        if (cnt_out !== 5'd3 || gnt !== 4'b0010) begin
            failures++; $display("FAIL mid_run_reached cnt_out=%0d gnt=%b exp 3/0010", cnt_out, gnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, done, busy, cnt_load, cnt_enab, cnt_in} !== 16'h0 || cnt_rst !== 1'b1) begin
            failures++; $display("FAIL mid_reset_outputs got=%h cnt_rst=%b exp 0/1",
                                 {gnt, done, busy, cnt_load, cnt_enab, cnt_in}, cnt_rst);
        end
        set_job(0, 5'd0, 5'd1);
        set_job(3, 5'd0, 5'd1);
        rst_n = 1'b1;
        req   = 4'b1011;
        #1;
        checks++;
        if (cnt_rst !== 1'b1) begin
            failures++; $display("FAIL mid_reset_clr got=%b exp=1", cnt_rst);
        end
        run_to_done(20, cyc, en_n, g_s, d_s, ld_at, ld_in, rs_n);
        checks++;
        if (d_s !== 4'b0001 || g_s !== 4'b0001) begin
            failures++; $display("FAIL mid_reset_first_served done=%b gnt=%b exp 0001/0001", d_s, g_s);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int cyc, en_n, ld_at, rs_n;
        logic [NREQ-1:0] g_s, d_s;
        logic [WIDTH-1:0] ld_in;
        set_job(2, 5'd0, 5'd10);
        set_job(3, 5'd0, 5'd1);
        req = 4'b1100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin
            failures++; $display("FAIL abort_grant got=%b exp=0100", gnt);
        end
        repeat (2) @(negedge clk);
        req = 4'b1000;
        #1;
`ifdef COUNTER_SCHED_ABORT_EN
        checks++;
        if (cnt_enab !== 1'b0) begin
            failures++; $display("FAIL abort_enab_low got=%b exp=0", cnt_enab);
        end
        @(negedge clk);
        checks++;
        if (cnt_rst !== 1'b1 || gnt !== 4'b0000 || done !== 4'b0000) begin
            failures++; $display("FAIL abort_clr cnt_rst=%b gnt=%b done=%b exp 1/0000/0000", cnt_rst, gnt, done);
        end
        run_to_done(20, cyc, en_n, g_s, d_s, ld_at, ld_in, rs_n);
        checks++;
        if (d_s !== 4'b1000 || g_s !== 4'b1000) begin
            failures++; $display("FAIL abort_next_grant done=%b gnt=%b exp 1000/1000", d_s, g_s);
        end
`else
        checks++;
        if (cnt_enab !== 1'b1) begin
            failures++; $display("FAIL noabort_enab got=%b exp=1", cnt_enab);
        end
        run_to_done(40, cyc, en_n, g_s, d_s, ld_at, ld_in, rs_n);
        checks++;
        if (d_s !== 4'b0100 || cnt_out !== 5'd10) begin
            failures++; $display("FAIL noabort_done done=%b cnt_out=%0d exp 0100/10", d_s, cnt_out);
        end
        run_to_done(20, cyc, en_n, g_s, d_s, ld_at, ld_in, rs_n);
        checks++;
        if (d_s !== 4'b1000) begin
            failures++; $display("FAIL noabort_next_grant done=%b exp=1000", d_s);
        end
`endif
        req = '0;
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_start = '0;
        req_end   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_equal();
        test_reset_mid_run();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
